// File: rtl/input_debouncer_if.sv
// Switch-side bundle for the debouncer: raw levels in,
// clean levels, edge pulses and the sample strobe out.
interface input_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] db_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic            tick;

  modport master (
    output raw_in,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  tick
  );

  modport slave (
    input  raw_in,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output tick
  );
endinterface

// File: rtl/input_debouncer.sv
// Per-channel 2-flop sync plus tick-sampled stability FSM;
// a level is accepted only after STABLE_TICKS agreeing ticks.
module input_debouncer #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input_debouncer_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } st_e;

  logic [PW-1:0]   pre_q, pre_d;
  logic            tick_w;
  logic [N_CH-1:0] meta_q, sync_q;
  st_e             state_q [N_CH];
  st_e             state_d [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;

  always_comb begin
    tick_w = (pre_q == PW'(TICK_DIV - 1));
    pre_d  = tick_w ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pre_q  <= '0;
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      pre_q  <= pre_d;
      meta_q <= bus.raw_in;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!Reset) begin
        state_q[i] <= ST_LO;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Pending states count agreeing ticks; one disagreeing tick aborts.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_w) begin
        unique case (state_q[i])
          ST_LO: begin
            if (sync_q[i]) begin
              if (STABLE_TICKS == 1) begin
                state_d[i] = ST_HI;
              end else begin
                state_d[i] = PEND_HI;
                cnt_d[i]   = CW'(1);
              end
            end
          end
          PEND_HI: begin
            if (!sync_q[i]) begin
              state_d[i] = ST_LO;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) >= CW'(STABLE_TICKS)) begin
              state_d[i] = ST_HI;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CW'(1);
            end
          end
          ST_HI: begin
            if (!sync_q[i]) begin
              if (STABLE_TICKS == 1) begin
                state_d[i] = ST_LO;
              end else begin
                state_d[i] = PEND_LO;
                cnt_d[i]   = CW'(1);
              end
            end
          end
          PEND_LO: begin
            if (sync_q[i]) begin
              state_d[i] = ST_HI;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) >= CW'(STABLE_TICKS)) begin
              state_d[i] = ST_LO;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i]   = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = ST_LO;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      db_d[i] = (state_d[i] == ST_HI) ||
                (state_d[i] == PEND_LO);
    end
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.tick       = tick_w;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: stimulus queues expected edge events,
// a negedge monitor pops one per observed pulse cycle.
module tb_input_debouncer;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LAT_MIN = 2 + (ST - 1) * TD + 1;
  localparam int LAT_MAX = LAT_MIN + TD - 1;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  input_debouncer_if #(.N_CH(N)) bus ();

  input_debouncer #(
    .N_CH(N),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [3:0] r,
                      input logic [3:0] f, input int lo,
                      input int hi, input string nm);
    exp_t e;
    e.db = d; e.rise = r; e.fall = f;
    e.lo = cyc + lo; e.hi = cyc + hi; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0",
               nm, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bus.rise_pulse !== 4'b0 || bus.fall_pulse !== 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=r%b_f%b_db%b required=none cyc=%0d",
                 bus.rise_pulse, bus.fall_pulse, bus.db_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_db"},   32'(bus.db_out),     32'(e.db));
        chk({e.name, "_rise"}, 32'(bus.rise_pulse), 32'(e.rise));
        chk({e.name, "_fall"}, 32'(bus.fall_pulse), 32'(e.fall));
        checks++;
        if (cyc < e.lo || cyc > e.hi) begin
          failures++;
          $display("FAIL %s_latency actual=%0d required=%0d..%0d",
                   e.name, cyc, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    Reset = 1'b0;
    bus.raw_in = 4'hF;
    step(3);
    chk("rst_db",   32'(bus.db_out),     32'h0);
    chk("rst_rise", 32'(bus.rise_pulse), 32'h0);
    chk("rst_fall", 32'(bus.fall_pulse), 32'h0);
    chk("rst_tick", 32'(bus.tick),       32'h0);

    // Prescaler at 0 on release, so tick shows after 3 more edges.
    Reset = 1'b1;
    bus.raw_in = 4'h0;
    k = 0;
    while (bus.tick !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("tick_first", 32'(k), 32'd3);
    step(5);

    bus.raw_in = 4'b0001;
    push(4'b0001, 4'b0001, 4'b0000, LAT_MIN, LAT_MAX, "t2_rise");
    drain("t2", 30);
    step(10);

    for (int i = 0; i < 8; i++) begin
      bus.raw_in[1] = ~bus.raw_in[1];
      step(5);
    end
    step(20);
    chk("t3_db", 32'(bus.db_out), 32'b0001);

    bus.raw_in[2] = 1'b1;
    push(4'b0101, 4'b0100, 4'b0000, LAT_MIN, LAT_MAX, "t4_rise");
    drain("t4", 30);
    step(10);
    bus.raw_in[2] = 1'b0;
    step(6);
    bus.raw_in[2] = 1'b1;
    step(20);
    chk("t4_db", 32'(bus.db_out), 32'b0101);

    bus.raw_in = 4'b1010;
    push(4'b1010, 4'b1010, 4'b0101, LAT_MIN, LAT_MAX, "t5a");
    drain("t5a", 30);
    step(10);
    bus.raw_in = 4'b0101;
    push(4'b0101, 4'b0101, 4'b1010, LAT_MIN, LAT_MAX, "t5b");
    drain("t5b", 30);
    step(10);

    bus.raw_in = 4'b1101;
    step(2);
    n = 0;
    k = 0;
    while (n < 2 && k < 20) begin
      if (bus.tick === 1'b1) n++;
      @(negedge clk);
      k++;
    end
    chk("t6_ticks", 32'(n), 32'd2);
    Reset = 1'b0;
    @(negedge clk);
    chk("t6_db",   32'(bus.db_out),     32'h0);
    chk("t6_rise", 32'(bus.rise_pulse), 32'h0);
    chk("t6_fall", 32'(bus.fall_pulse), 32'h0);
    // Fresh prescaler and sync: ticks land on edges +4, +8, +12.
    Reset = 1'b1;
    push(4'b1101, 4'b1101, 4'b0000, 12, 12, "t6_restart");
    drain("t6", 30);
    step(10);
    chk("t6_final_db", 32'(bus.db_out), 32'b1101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
